mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 7 bits: instruction-register opcode field, sampled in DECODE.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory completion for the current access.
REQ-005 SHALL have port alu_op, output, 2 bits: to the ALU control unit; 00 add, 01 subtract, 10 funct-decoded.
REQ-006 SHALL have port alu_src_a, output, 1 bit: 0 selects PC, 1 selects rs1.
REQ-007 SHALL have port alu_src_b, output, 2 bits: 00 rs2, 01 constant 4, 10 immediate, 11 branch/jump offset.
REQ-008 SHALL have ports mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond, i_or_d, outputs, 1 bit each: datapath strobes and selects.
REQ-009 SHALL have port pc_source, output, 1 bit: 0 selects ALU result, 1 selects ALUOut register.
REQ-010 SHALL have port mem_to_reg, output, 2 bits: 00 ALUOut, 01 memory data, 10 PC.
REQ-011 SHALL have port state, output, 4 bits: current state encoding.
REQ-012 SHALL have port illegal_instr, output, 1 bit: trap indication; present only with the Configuration feature.

Function
REQ-013 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, I_EXEC=7, ALU_WB=8, BRANCH=9, JAL=10, TRAP=11.
REQ-014 SHALL drive each unlisted strobe to 0 and each unlisted select to 0 in every state.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_source=0, ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-016 DECODE: alu_src_b=11, alu_op=00; next state from opcode: 0000011 and 0100011 -> MEM_ADDR; 0110011 -> R_EXEC; 0010011 -> I_EXEC; 1100011 -> BRANCH; 1101111 -> JAL; any other value -> FETCH, or TRAP with the Configuration feature.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state is MEM_RD if opcode=0000011, otherwise MEM_WR.
REQ-018 MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready=1, then goes to MEM_WB.
REQ-019 MEM_WR: mem_write=1, i_or_d=1; holds until mem_ready=1, then goes to FETCH.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=01; goes to FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=10; both go to ALU_WB.
REQ-022 ALU_WB: reg_write=1, mem_to_reg=00; goes to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; goes to FETCH.
REQ-024 JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10; goes to FETCH.
REQ-025 SHALL give the following instruction latencies with mem_ready=1 throughout: R/I 4 cycles, load 5, store 4, branch 3, jal 3.
REQ-026 Unused state encodings 12-15 SHALL go to FETCH on the next edge with all strobes 0.

Reset
REQ-027 rst=1 SHALL force state=FETCH immediately, independent of clk.
REQ-028 While rst=1, mem_read, mem_write, ir_write, reg_write, pc_write and pc_write_cond SHALL be 0; alu_op=00, alu_src_b=01, and all other outputs SHALL be 0.
REQ-029 Reset asserted in any state, including mid-wait in MEM_RD or MEM_WR, SHALL abandon the operation; the first cycle after deassertion SHALL be FETCH.

Configuration
REQ-030 Macro MC_CU_ILLEGAL_TRAP_EN: when defined, an unknown opcode in DECODE SHALL go to TRAP. TRAP SHALL hold illegal_instr=1 with all strobes 0 and SHALL be exited only by rst. When the macro is undefined, the illegal_instr port and the TRAP state SHALL be absent, and an unknown opcode SHALL return to FETCH with no writes.

Verification
REQ-031 Reset is released with mem_ready=1 and opcode=0110011 -> state sequence 0,1,6,8,0; alu_op=10 in R_EXEC; reg_write=1 only in ALU_WB.
REQ-032 opcode=0000011, mem_ready held at 0 for 3 cycles in MEM_RD -> state stays 3 for 3 cycles, then goes to 4 with mem_to_reg=01 and reg_write=1.
REQ-033 opcode=1100011 -> state sequence 0,1,9,0; pc_write_cond=1 and alu_op=01 only in BRANCH.
REQ-034 rst is pulsed asynchronously mid-cycle while in MEM_WR -> state=0 and mem_write=0 before the next clk edge.
REQ-035 opcode=1111111 -> with MC_CU_ILLEGAL_TRAP_EN, state=11 and illegal_instr=1 held for 10 cycles; without it, state returns to 0 with no strobe asserted.

Source files
------------

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Moore main-control FSM for a multi-cycle RISC-V style datapath. Steps each
// instruction through fetch, decode and its execute/memory/write-back states
// and drives the datapath selects and write strobes from the current state.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : asynchronous, active-high reset (forces FETCH)
//   opcode        : instruction-register opcode field
//   mem_ready     : memory completion for the current access
//   alu_op        : 00 add, 01 subtract, 10 funct-decoded
//   alu_src_a     : 0 PC, 1 rs1
//   alu_src_b     : 00 rs2, 01 constant 4, 10 immediate, 11 branch/jump offset
//   mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond, i_or_d
//                 : datapath strobes and selects
//   pc_source     : 0 ALU result, 1 ALUOut register
//   mem_to_reg    : 00 ALUOut, 01 memory data, 10 PC
//   illegal_instr : trap indication (only with MC_CU_ILLEGAL_TRAP_EN)
//   state         : current state encoding
//
// Build option
//   MC_CU_ILLEGAL_TRAP_EN : unknown opcodes enter a sticky TRAP state that is
//                           left only through rst; otherwise they return to
//                           FETCH without any write.
// ---------------------------------------------------------------------------
module mc_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       pc_source,
    output logic [1:0] mem_to_reg,
`ifdef MC_CU_ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic [3:0] state
);

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        I_EXEC   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
`ifdef MC_CU_ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd11
`endif
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d       = FETCH;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        pc_source     = 1'b0;
        mem_to_reg    = 2'b00;
`ifdef MC_CU_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC latch together on the cycle memory delivers
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = MEM_ADDR;
                    OP_RTYPE:  state_d = R_EXEC;
                    OP_ITYPE:  state_d = I_EXEC;
                    OP_BRANCH: state_d = BRANCH;
                    OP_JAL:    state_d = JAL;
`ifdef MC_CU_ILLEGAL_TRAP_EN
                    default:   state_d = TRAP;
`else
                    default:   state_d = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                state_d       = FETCH;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                state_d    = FETCH;
            end
`ifdef MC_CU_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal_instr = 1'b1;
                state_d       = TRAP;
            end
`endif
            // Unused encodings recover to FETCH with everything idle
            default: state_d = FETCH;
        endcase

        // Reset is asynchronous, so the FETCH read/latch strobes must be
        // suppressed combinationally while it is held
        if (rst) begin
            alu_op        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            pc_source     = 1'b0;
            mem_to_reg    = 2'b00;
`ifdef MC_CU_ILLEGAL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Scoreboard bench for mc_control_unit: each instruction's per-cycle stimulus
// and expected state/outputs are queued, then replayed one cycle at a time
// and compared half a cycle after the rising edge.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // Outputs packed as {alu_op, alu_src_a, alu_src_b, mem_read, mem_write,
    // ir_write, reg_write, pc_write, pc_write_cond, i_or_d, pc_source, mem_to_reg}
    localparam logic [14:0] RST_VEC = 15'h0400;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       pc_source;
    logic [1:0] mem_to_reg;
    logic [3:0] state;
`ifdef MC_CU_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    logic [14:0] dut_out;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    typedef struct packed {
        logic [6:0] op;
        logic       mr;
    } stim_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] out;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    mc_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .pc_source     (pc_source),
        .mem_to_reg    (mem_to_reg),
`ifdef MC_CU_ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .state         (state)
    );

    assign dut_out = {alu_op, alu_src_a, alu_src_b, mem_read, mem_write,
                      ir_write, reg_write, pc_write, pc_write_cond, i_or_d,
                      pc_source, mem_to_reg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "tb_mc_control_unit timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected Moore outputs of a state, written out from the control table
    function automatic logic [14:0] spec_out(input logic [3:0] st, input logic mr);
        logic [1:0] a_op, src_b, m2r;
        logic       src_a, mrd, mwr, irw, rgw, pcw, pcc, iod, pcs;
        a_op = 2'b00; src_b = 2'b00; m2r = 2'b00;
        src_a = 0; mrd = 0; mwr = 0; irw = 0; rgw = 0; pcw = 0; pcc = 0; iod = 0; pcs = 0;
        case (st)
            4'd0:  begin mrd = 1; src_b = 2'b01; irw = mr; pcw = mr; end
            4'd1:  src_b = 2'b11;
            4'd2:  begin src_a = 1; src_b = 2'b10; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin rgw = 1; m2r = 2'b01; end
            4'd5:  begin mwr = 1; iod = 1; end
            4'd6:  begin src_a = 1; a_op = 2'b10; end
            4'd7:  begin src_a = 1; src_b = 2'b10; a_op = 2'b10; end
            4'd8:  rgw = 1;
            4'd9:  begin src_a = 1; a_op = 2'b01; pcc = 1; pcs = 1; end
            4'd10: begin pcw = 1; pcs = 1; rgw = 1; m2r = 2'b10; end
            default: ;
        endcase
        return {a_op, src_a, src_b, mrd, mwr, irw, rgw, pcw, pcc, iod, pcs, m2r};
    endfunction

    task automatic push_step(input logic [6:0] op, input logic mr, input logic [3:0] st);
        stim_t s;
        exp_t  e;
        s.op  = op;
        s.mr  = mr;
        e.st  = st;
        e.out = spec_out(st, mr);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Entered just after a falling edge; leaves at the next falling edge
    // after the last queued cycle.
    task automatic drain();
        stim_t s;
        exp_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode    = s.op;
            mem_ready = s.mr;
            #1;
            e = exp_q.pop_front();
            check_val($sformatf("step%0d_state", step_no), 32'(state), 32'(e.st));
            check_val($sformatf("step%0d_outs", step_no), 32'(dut_out), 32'(e.out));
`ifdef MC_CU_ILLEGAL_TRAP_EN
            check_val($sformatf("step%0d_illegal", step_no), 32'(illegal_instr),
                      32'(e.st == 4'd11));
`endif
            step_no++;
            @(negedge clk);
        end
    endtask

    // Pulse reset mid-cycle and confirm it acts before the next rising edge
    task automatic async_reset_check(input string tag, input logic [3:0] st_before);
        #1;
        check_val({tag, "_pre_state"}, 32'(state), 32'(st_before));
        #1;
        rst = 1'b1;
        #1;
        check_val({tag, "_rst_state"}, 32'(state), 32'(0));
        check_val({tag, "_rst_outs"}, 32'(dut_out), 32'(RST_VEC));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = OP_RTYPE;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_state", 32'(state), 32'(0));
        check_val("reset_outs", 32'(dut_out), 32'(RST_VEC));
        @(negedge clk);
        rst = 1'b0;

        // R-type: 0,1,6,8 then next FETCH
        push_step(OP_RTYPE, 1, 0); push_step(OP_RTYPE, 1, 1);
        push_step(OP_RTYPE, 1, 6); push_step(OP_RTYPE, 1, 8);
        // Load with three wait cycles in MEM_RD
        push_step(OP_LOAD, 1, 0); push_step(OP_LOAD, 1, 1); push_step(OP_LOAD, 1, 2);
        push_step(OP_LOAD, 0, 3); push_step(OP_LOAD, 0, 3); push_step(OP_LOAD, 0, 3);
        push_step(OP_LOAD, 1, 3); push_step(OP_LOAD, 1, 4);
        // Branch
        push_step(OP_BRANCH, 1, 0); push_step(OP_BRANCH, 1, 1); push_step(OP_BRANCH, 1, 9);
        // JAL with a stalled fetch
        push_step(OP_JAL, 0, 0); push_step(OP_JAL, 1, 0);
        push_step(OP_JAL, 1, 1); push_step(OP_JAL, 1, 10);
        // I-type
        push_step(OP_ITYPE, 1, 0); push_step(OP_ITYPE, 1, 1);
        push_step(OP_ITYPE, 1, 7); push_step(OP_ITYPE, 1, 8);
        // Store without waits
        push_step(OP_STORE, 1, 0); push_step(OP_STORE, 1, 1);
        push_step(OP_STORE, 1, 2); push_step(OP_STORE, 1, 5);
        // Store stalled in MEM_WR, reset arrives mid-wait
        push_step(OP_STORE, 1, 0); push_step(OP_STORE, 1, 1);
        push_step(OP_STORE, 0, 2); push_step(OP_STORE, 0, 5);
        drain();
        async_reset_check("mem_wr", 4'd5);

        // Load stalled in MEM_RD, reset arrives mid-wait
        push_step(OP_LOAD, 1, 0); push_step(OP_LOAD, 1, 1);
        push_step(OP_LOAD, 0, 2); push_step(OP_LOAD, 0, 3);
        drain();
        async_reset_check("mem_rd", 4'd3);

        // Unknown opcode
        push_step(OP_BAD, 1, 0); push_step(OP_BAD, 1, 1);
`ifdef MC_CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 11; i++) push_step(OP_BAD, 1, 11);
`else
        push_step(OP_BAD, 1, 0);
        push_step(OP_RTYPE, 1, 1);
        push_step(OP_RTYPE, 1, 6);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
